button_debouncer: RTL and testbench

- Input-side counterpart to the board's LED drivers; conditions raw push-button pins into clean signals for the fabric.
- Per channel:
  - two-flop synchroniser
  - counter-based debounce
  - press/release edge pulses
  - long-press detection
- Sits directly behind the top-level button pins; runs on the 16 MHz board clock.

---
 rtl/button_debouncer_if.sv | 29 ++
 rtl/button_debouncer.sv | 114 +++++++++++
 tb/tb_button_debouncer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - raw button pins in, conditioned button events out
// Signals:
//   pin_btn     raw asynchronous button pins (board side drives)
//   btn_level   debounced state, 1 = pressed
//   btn_press   one-cycle pulse on debounced 0->1
//   btn_release one-cycle pulse on debounced 1->0
//   btn_long    one-cycle pulse when a press has lasted HOLD_CYCLES
//   btn_held    1 from btn_long until release
// Modports: master = pin driver / consumer, slave = the debouncer.
interface button_debouncer_if #(
  parameter int NUM_BUTTONS = 4
);
  logic [NUM_BUTTONS-1:0] pin_btn;
  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] btn_release;
  logic [NUM_BUTTONS-1:0] btn_long;
  logic [NUM_BUTTONS-1:0] btn_held;

  modport master (
    output pin_btn,
    input  btn_level, btn_press, btn_release, btn_long, btn_held
  );

  modport slave (
    input  pin_btn,
    output btn_level, btn_press, btn_release, btn_long, btn_held
  );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-channel push-button synchroniser, debouncer and long-press detector
// Ports:
//   pin_clk_16M  board clock, all logic on its rising edge
//   pin_reset_n  asynchronous active-low reset
//   bus          button_debouncer_if.slave: pin_btn in; btn_level/press/release/long/held out
// All outputs are registered; there is no combinational path from pin_btn.
module button_debouncer #(
  parameter int NUM_BUTTONS     = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 160000,
  parameter int HOLD_CYCLES     = 16000000
) (
  input  logic              pin_clk_16M,
  input  logic              pin_reset_n,
  button_debouncer_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);
  // Pin level of a released button; also the polarity-normalisation mask.
  localparam logic [NUM_BUTTONS-1:0] PIN_IDLE = {NUM_BUTTONS{ACTIVE_LOW}};

  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;
  logic [NUM_BUTTONS-1:0] r_level;
  logic [NUM_BUTTONS-1:0] r_press;
  logic [NUM_BUTTONS-1:0] r_release;
  logic [NUM_BUTTONS-1:0] r_long;
  logic [NUM_BUTTONS-1:0] r_held;
  logic [DW-1:0]          r_deb_cnt  [NUM_BUTTONS];
  logic [HW-1:0]          r_hold_cnt [NUM_BUTTONS];

  logic [NUM_BUTTONS-1:0] w_sample;
  logic [NUM_BUTTONS-1:0] w_accept;

  // The synchroniser keeps raw pin levels so it resets to the idle pin
  // level; normalising after sync2 gives 1 = pressed with identical timing.
  always_ff @(posedge pin_clk_16M or negedge pin_reset_n) begin
    if (!pin_reset_n) begin
      r_sync1 <= PIN_IDLE;
      r_sync2 <= PIN_IDLE;
    end else begin
      r_sync1 <= bus.pin_btn;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_sample = r_sync2 ^ PIN_IDLE;
    w_accept = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      // DEBOUNCE_CYCLES-th consecutive disagreement: take the new level.
      w_accept[i] = (w_sample[i] != r_level[i]) && (r_deb_cnt[i] == DEB_LAST);
    end
  end

  always_ff @(posedge pin_clk_16M or negedge pin_reset_n) begin
    if (!pin_reset_n) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_held    <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_deb_cnt[i]  <= '0;
        r_hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_press[i]   <= 1'b0;
        r_release[i] <= 1'b0;
        r_long[i]    <= 1'b0;

        // Any agreement (including a one-cycle bounce) restarts the count.
        if (w_sample[i] == r_level[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_deb_cnt[i] <= '0;
          r_level[i]   <= w_sample[i];
          r_press[i]   <= w_sample[i];
          r_release[i] <= ~w_sample[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end

        // A release on the same edge as the hold threshold wins: no long
        // event is reported for a press that is already ending.
        if (w_accept[i] && r_level[i]) begin
          r_hold_cnt[i] <= '0;
          r_held[i]     <= 1'b0;
        end else if (!r_level[i]) begin
          r_hold_cnt[i] <= '0;
        end else begin
          if ((r_hold_cnt[i] == HOLD_LAST) && !r_held[i]) begin
            r_long[i] <= 1'b1;
            r_held[i] <= 1'b1;
          end
          // Saturate past the threshold so the long event cannot repeat.
          if (r_hold_cnt[i] != HOLD_SAT) begin
            r_hold_cnt[i] <= r_hold_cnt[i] + HW'(1);
          end
        end
      end
    end
  end

  assign bus.btn_level   = r_level;
  assign bus.btn_press   = r_press;
  assign bus.btn_release = r_release;
  assign bus.btn_long    = r_long;
  assign bus.btn_held    = r_held;
endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer with a sliding-window reference model
module tb_button_debouncer;
  localparam int N = 4;
  localparam int D = 4;
  localparam int H = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  button_debouncer_if #(.NUM_BUTTONS(N)) bus ();

  button_debouncer #(
    .NUM_BUTTONS(N),
    .ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H)
  ) dut (
    .pin_clk_16M(clk),
    .pin_reset_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
    logic [N-1:0] lng;
    logic [N-1:0] hld;
  } exp_t;

  exp_t         sb[$];
  exp_t         mx;
  int           total = 0;
  int           bad = 0;

  // Reference model: the debounced level flips at an edge exactly when the
  // last D synchronised samples (pin samples from 2..D+1 edges back) all
  // oppose it. Long press is a fixed distance H from the press edge.
  logic [N-1:0] ph[$];
  logic [N-1:0] m_level;
  logic [N-1:0] m_held;
  int           m_press_edge [N];
  int           m_edge = 0;

  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    m_held  = '0;
    ph.delete();
    repeat (D + 2) ph.push_back('0);
  endtask

  task automatic step(input logic [N-1:0] pin, input logic rn, input bit chk_async);
    exp_t         ex;
    logic [N-1:0] p;
    bit           all_opp;
    @(negedge clk);
    #1;
    bus.pin_btn = pin;
    rst_n       = rn;
    ex          = '0;
    if (!rn) begin
      model_reset();
      if (chk_async) begin
        #1;
        cmp("async_level",   bus.btn_level,   '0);
        cmp("async_press",   bus.btn_press,   '0);
        cmp("async_release", bus.btn_release, '0);
        cmp("async_long",    bus.btn_long,    '0);
        cmp("async_held",    bus.btn_held,    '0);
      end
    end else begin
      m_edge++;
      p = ~pin;
      for (int c = 0; c < N; c++) begin
        all_opp = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (ph[ph.size() - 2 - j][c] == m_level[c]) all_opp = 1'b0;
        end
        if (all_opp) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) begin
            ex.prs[c]       = 1'b1;
            m_press_edge[c] = m_edge;
          end else begin
            ex.rls[c] = 1'b1;
            m_held[c] = 1'b0;
          end
        end else if (m_level[c] && !m_held[c] && (m_edge - m_press_edge[c] == H)) begin
          ex.lng[c] = 1'b1;
          m_held[c] = 1'b1;
        end
      end
      ph.push_back(p);
      void'(ph.pop_front());
    end
    ex.lvl = m_level;
    ex.hld = m_held;
    sb.push_back(ex);
  endtask

  // Monitor: the expectation for edge e is pushed before e and popped at
  // the falling edge after e.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mx = sb.pop_front();
      cmp("level",   bus.btn_level,   mx.lvl);
      cmp("press",   bus.btn_press,   mx.prs);
      cmp("release", bus.btn_release, mx.rls);
      cmp("long",    bus.btn_long,    mx.lng);
      cmp("held",    bus.btn_held,    mx.hld);
    end
  end

  logic [N-1:0] rp;
  int           run_left [N];

  initial begin
    bus.pin_btn = '1;
    model_reset();

    // Reset with all buttons released, then idle.
    repeat (3) step(4'hF, 1'b0, 1'b0);
    repeat (50) step(4'hF, 1'b1, 1'b0);

    // Clean press on channel 0, held long enough to reach btn_held.
    repeat (30) step(4'hE, 1'b1, 1'b0);
    cmp("held0_before_reset", bus.btn_held & 4'h1, 4'h1);

    // Mid-operation reset with the button still down: fresh press follows.
    step(4'hE, 1'b0, 1'b1);
    repeat (12) step(4'hE, 1'b1, 1'b0);
    repeat (10) step(4'hF, 1'b1, 1'b0);

    // Bounce on channel 1, then a steady press and release.
    repeat (5) begin
      repeat (3) step(4'hD, 1'b1, 1'b0);
      step(4'hF, 1'b1, 1'b0);
    end
    repeat (10) step(4'hD, 1'b1, 1'b0);
    repeat (10) step(4'hF, 1'b1, 1'b0);

    // Long press on channel 2, held well past the threshold.
    repeat (70) step(4'hB, 1'b1, 1'b0);
    repeat (10) step(4'hF, 1'b1, 1'b0);

    // Short press on channel 3.
    repeat (10) step(4'h7, 1'b1, 1'b0);
    repeat (10) step(4'hF, 1'b1, 1'b0);

    // Randomised bouncy pins on all channels with occasional resets.
    rp = '1;
    for (int c = 0; c < N; c++) run_left[c] = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        run_left[c]--;
        if (run_left[c] <= 0) begin
          rp[c] = ~rp[c];
          run_left[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(4, 45));
        end
      end
      if ($urandom_range(0, 599) == 0) step(rp, 1'b0, 1'b1);
      else                             step(rp, 1'b1, 1'b0);
    end

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
